step_renderer: RTL and testbench
================================

STEP_RENDERER -- requirements
Module: step_renderer

Interface
REQ-001 SHALL have parameter STEP_WIDTH_X, default 50, meaning step width in pixels.
REQ-002 SHALL have parameter STEP_HEIGHT_Y, default 7, meaning step height in pixels.
REQ-003 SHALL have parameters STEP_TILE_OFFSET_X and STEP_TILE_OFFSET_Y, defaults 7 and 50, meaning step top-left offset from the tile top-left corner.
REQ-004 SHALL have parameters TILE_W and TILE_H, defaults 64 and 64, meaning the WALL extent.
REQ-005 SHALL have parameter SPIKE_MAX_H, default 20, meaning maximum spike height in pixels (1..63).
REQ-006 SHALL have parameter HOLD_FRAMES, default 30, meaning frames spent in each hold state (1..255).
REQ-007 SHALL have parameter COLOR[type], 8-bit per type (REGU 8'h8b, GATE 8'h1c, DEATH 8'he0, WALL 8'h49, SPIKE 8'hb6).
REQ-008 SHALL have ports in this order: clk in 1 (clock); resetN in 1 (reset, asynchronous, active-low).
REQ-009 startOfFrame  in  1  one-cycle pulse at frame start.
REQ-010 enable_anim  in  1  spike animation runs when high.
REQ-011 pixelX, pixelY  in  11 each  current VGA pixel.
REQ-012 tileTopLeftX, tileTopLeftY  in  11 each  tile position in the grid.
REQ-013 step_type  in  3  FREE=0, REGU=1, GATE=2, DEATH=3, WALL=4, SPIKE=5; codes 6-7 are invalid.
REQ-014 offsetX, offsetY  out  11 each  pixel offset from the drawn region's top-left.
REQ-015 drawingRequest  out  1  pixel lies inside the drawn region.
REQ-016 RGBout  out  8  pixel colour.
REQ-017 spikeHeight  out  6  current spike height.
REQ-018 spikeActive  out  1  spike is lethal.

Function
REQ-019 Pixel outputs SHALL be registered with 1-cycle latency from pixelX/pixelY/tile/step_type.
REQ-020 Step rectangle SHALL be x in [tileX+OFF_X, tileX+OFF_X+W) and y in [tileY+OFF_Y, tileY+OFF_Y+H). Arithmetic SHALL be 12-bit unsigned, with no wrap.
REQ-021 REGU, GATE and DEATH SHALL draw the step rectangle in COLOR[type].
REQ-022 WALL SHALL draw [tileX, tileX+TILE_W) x [tileY, tileY+TILE_H).
REQ-023 SPIKE SHALL draw x in the step range and y in [max(0, stepTop-spikeHeight), stepBottom). The top is clamped at 0 with no underflow.
REQ-024 Inside a region: drawingRequest=1, RGBout=COLOR[type], offsets=pixel minus region top-left.
REQ-025 Outside a region, for FREE, or for an invalid type: drawingRequest=0, RGBout=8'hFF (transparent), offsets=0.
REQ-026 The animation FSM SHALL have states RETRACTED, RISING, EXTENDED, FALLING, and SHALL advance only on startOfFrame with enable_anim=1.
REQ-027 RETRACTED: spikeHeight=0; count HOLD_FRAMES frames, then go to RISING.
REQ-028 RISING: spikeHeight +1 per frame; when it reaches SPIKE_MAX_H, go to EXTENDED.
REQ-029 EXTENDED: hold HOLD_FRAMES frames, then go to FALLING.
REQ-030 FALLING: spikeHeight -1 per frame; when it reaches 0, go to RETRACTED.
REQ-031 The frame counter SHALL reset to 0 on every state entry. spikeHeight SHALL saturate at 0 and SPIKE_MAX_H.
REQ-032 With enable_anim=0, state, counter and spikeHeight SHALL freeze. startOfFrame is ignored.
REQ-033 spikeActive SHALL be a registered output, =1 iff spikeHeight >= SPIKE_MAX_H/2 (integer division).
REQ-034 A startOfFrame pulse coinciding with a pixel draw SHALL affect drawing from the next cycle only.
REQ-035 All tiles SHALL share one animation phase.

Reset
REQ-036 While resetN=0: state=RETRACTED, counter=0, spikeHeight=0, spikeActive=0, drawingRequest=0, RGBout=8'h00, offsets=0.
REQ-037 Reset asserted mid-animation SHALL take effect asynchronously. After release, the sequence SHALL restart from RETRACTED.

Structure
REQ-038 Package step_pkg SHALL hold the step_type_e enum, the TRANSPARENT_ENCODING constant and the default colour constants.
REQ-039 The animation FSM SHALL be the sub-module spike_anim_fsm, with ports clk, resetN, startOfFrame, enable_anim, spikeHeight and spikeActive. The region and colour logic SHALL remain in step_renderer.

Verification
REQ-040 Reset test: tile (64,64), REGU, pixel (71,114) -> next cycle drawingRequest=1, RGB=8'h8b, offsets (0,0); pixel (121,114) -> drawingRequest=0, RGB=8'hFF.
REQ-041 Wall test: WALL at tile (0,0), pixel (63,63) -> draw, offsets (63,63); pixel (64,63) -> no draw.
REQ-042 Animation test: enable_anim=1 with frame pulses. After 30 pulses, state=RISING. After 20 more pulses, spikeHeight=20 and spikeActive=1. After 30 more, FALLING. After 20 more, spikeHeight=0.
REQ-043 Spike clamp test: spikeHeight=20, SPIKE at tile (0,-0 edge) with OFF_Y=0 -> top clamped to 0; pixel (7,0) draws with offsetY=0 and no underflow.
REQ-044 Freeze and reset test: enable_anim=0 for 10 pulses mid-RISING at height 5 -> height stays 5. Then assert resetN=0 -> spikeHeight=0 immediately. After release, 30 pulses are needed before rising.
REQ-045 Invalid type test: step_type=7 -> drawingRequest=0 at every pixel.

Source files
------------

// File: rtl/step_pkg.sv
// Shared types and constants for the step renderer: step kinds, spike
// animation phases and the default palette.
package step_pkg;

  typedef enum logic [2:0] {
    STEP_FREE  = 3'd0,
    STEP_REGU  = 3'd1,
    STEP_GATE  = 3'd2,
    STEP_DEATH = 3'd3,
    STEP_WALL  = 3'd4,
    STEP_SPIKE = 3'd5
  } step_type_e;

  typedef enum logic [1:0] {
    ANIM_RETRACTED = 2'd0,
    ANIM_RISING    = 2'd1,
    ANIM_EXTENDED  = 2'd2,
    ANIM_FALLING   = 2'd3
  } anim_state_e;

  // Colour value the compositor treats as "nothing drawn here".
  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  localparam logic [7:0] COLOR_REGU_DEFAULT  = 8'h8b;
  localparam logic [7:0] COLOR_GATE_DEFAULT  = 8'h1c;
  localparam logic [7:0] COLOR_DEATH_DEFAULT = 8'he0;
  localparam logic [7:0] COLOR_WALL_DEFAULT  = 8'h49;
  localparam logic [7:0] COLOR_SPIKE_DEFAULT = 8'hb6;

endpackage

// File: rtl/spike_anim_fsm.sv
// Global spike animation: retracted hold, rise, extended hold, fall.
// Advances once per frame pulse while enable_anim is high; every tile
// shares this single phase.
module spike_anim_fsm
  import step_pkg::*;
#(
  parameter int SPIKE_MAX_H = 20,
  parameter int HOLD_FRAMES = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable_anim,
  output logic [5:0] spikeHeight,
  output logic       spikeActive
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [5:0] MAX_H     = 6'(SPIKE_MAX_H);
  localparam logic [5:0] HALF_H    = 6'(SPIKE_MAX_H / 2);

  anim_state_e state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [5:0]  height_q, height_d;
  logic        active_q;

  // Next phase, frame count and height; all frozen unless a frame pulse
  // arrives with animation enabled.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    height_d = height_q;
    if (startOfFrame && enable_anim) begin
      case (state_q)
        ANIM_RETRACTED: begin
          height_d = 6'd0;
          if (count_q >= HOLD_LAST) begin
            state_d = ANIM_RISING;
            count_d = 8'd0;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        ANIM_RISING: begin
          if (height_q >= MAX_H - 6'd1) begin
            height_d = MAX_H;
            state_d  = ANIM_EXTENDED;
            count_d  = 8'd0;
          end else begin
            height_d = height_q + 6'd1;
          end
        end
        ANIM_EXTENDED: begin
          height_d = MAX_H;
          if (count_q >= HOLD_LAST) begin
            state_d = ANIM_FALLING;
            count_d = 8'd0;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        ANIM_FALLING: begin
          if (height_q <= 6'd1) begin
            height_d = 6'd0;
            state_d  = ANIM_RETRACTED;
            count_d  = 8'd0;
          end else begin
            height_d = height_q - 6'd1;
          end
        end
        default: begin
          state_d  = ANIM_RETRACTED;
          count_d  = 8'd0;
          height_d = 6'd0;
        end
      endcase
    end
  end

  // Phase registers; lethality is registered from the next height so it
  // always agrees with the height presented in the same cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ANIM_RETRACTED;
      count_q  <= 8'd0;
      height_q <= 6'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      height_q <= height_d;
      active_q <= (height_d >= HALF_H);
    end
  end

  assign spikeHeight = height_q;
  assign spikeActive = active_q;

endmodule

// File: rtl/step_renderer.sv
// Per-pixel renderer for one stair tile: decides whether the current VGA
// pixel falls inside the tile's step, wall or spike region and returns its
// colour and offset one cycle later.
module step_renderer
  import step_pkg::*;
#(
  parameter int STEP_WIDTH_X       = 50,
  parameter int STEP_HEIGHT_Y      = 7,
  parameter int STEP_TILE_OFFSET_X = 7,
  parameter int STEP_TILE_OFFSET_Y = 50,
  parameter int TILE_W             = 64,
  parameter int TILE_H             = 64,
  parameter int SPIKE_MAX_H        = 20,
  parameter int HOLD_FRAMES        = 30,
  parameter logic [7:0] COLOR_REGU  = COLOR_REGU_DEFAULT,
  parameter logic [7:0] COLOR_GATE  = COLOR_GATE_DEFAULT,
  parameter logic [7:0] COLOR_DEATH = COLOR_DEATH_DEFAULT,
  parameter logic [7:0] COLOR_WALL  = COLOR_WALL_DEFAULT,
  parameter logic [7:0] COLOR_SPIKE = COLOR_SPIKE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        enable_anim,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] tileTopLeftX,
  input  logic [10:0] tileTopLeftY,
  input  logic [2:0]  step_type,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [5:0]  spikeHeight,
  output logic        spikeActive
);

  spike_anim_fsm #(
    .SPIKE_MAX_H (SPIKE_MAX_H),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_anim (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .enable_anim  (enable_anim),
    .spikeHeight  (spikeHeight),
    .spikeActive  (spikeActive)
  );

  // All geometry is done one bit wider than the pixel bus so edges near
  // the right/bottom of the coordinate space never wrap.
  logic [11:0] pixX, pixY, tileX, tileY;
  logic [11:0] stepLeft, stepRight, stepTop, stepBottom;
  logic [11:0] heightExt, spikeTop;
  logic        inStepX, inStepY, inSpikeY, inWallX, inWallY;

  assign pixX       = {1'b0, pixelX};
  assign pixY       = {1'b0, pixelY};
  assign tileX      = {1'b0, tileTopLeftX};
  assign tileY      = {1'b0, tileTopLeftY};
  assign stepLeft   = tileX + 12'(STEP_TILE_OFFSET_X);
  assign stepRight  = stepLeft + 12'(STEP_WIDTH_X);
  assign stepTop    = tileY + 12'(STEP_TILE_OFFSET_Y);
  assign stepBottom = stepTop + 12'(STEP_HEIGHT_Y);
  assign heightExt  = {6'd0, spikeHeight};
  assign spikeTop   = (stepTop >= heightExt) ? (stepTop - heightExt) : 12'd0;
  assign inStepX    = (pixX >= stepLeft) && (pixX < stepRight);
  assign inStepY    = (pixY >= stepTop) && (pixY < stepBottom);
  assign inSpikeY   = (pixY >= spikeTop) && (pixY < stepBottom);
  assign inWallX    = (pixX >= tileX) && (pixX < tileX + 12'(TILE_W));
  assign inWallY    = (pixY >= tileY) && (pixY < tileY + 12'(TILE_H));

  logic        inRegion;
  logic [11:0] regionLeft, regionTop;
  logic [7:0]  regionColor;
  logic [10:0] offsetX_d, offsetY_d;
  logic        drawing_d;
  logic [7:0]  rgb_d;

  // Pick the region and colour for this step kind; FREE and the unused
  // codes never draw.
  always_comb begin
    inRegion    = 1'b0;
    regionLeft  = 12'd0;
    regionTop   = 12'd0;
    regionColor = TRANSPARENT_ENCODING;
    case (step_type)
      STEP_REGU: begin
        inRegion = inStepX && inStepY;  regionLeft = stepLeft;  regionTop = stepTop;
        regionColor = COLOR_REGU;
      end
      STEP_GATE: begin
        inRegion = inStepX && inStepY;  regionLeft = stepLeft;  regionTop = stepTop;
        regionColor = COLOR_GATE;
      end
      STEP_DEATH: begin
        inRegion = inStepX && inStepY;  regionLeft = stepLeft;  regionTop = stepTop;
        regionColor = COLOR_DEATH;
      end
      STEP_WALL: begin
        inRegion = inWallX && inWallY;  regionLeft = tileX;  regionTop = tileY;
        regionColor = COLOR_WALL;
      end
      STEP_SPIKE: begin
        inRegion = inStepX && inSpikeY;  regionLeft = stepLeft;  regionTop = spikeTop;
        regionColor = COLOR_SPIKE;
      end
      default: ;
    endcase

    drawing_d = inRegion;
    rgb_d     = inRegion ? regionColor : TRANSPARENT_ENCODING;
    offsetX_d = inRegion ? 11'(pixX - regionLeft) : 11'd0;
    offsetY_d = inRegion ? 11'(pixY - regionTop) : 11'd0;
  end

  // Register the pixel result so it lines up one cycle behind the pixel.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
      offsetX        <= 11'd0;
      offsetY        <= 11'd0;
    end else begin
      drawingRequest <= drawing_d;
      RGBout         <= rgb_d;
      offsetX        <= offsetX_d;
      offsetY        <= offsetY_d;
    end
  end

endmodule

// File: tb/tb_step_renderer.sv
// Directed bench for step_renderer: pixel regions/colours through an
// expectation queue, plus the spike animation timeline, freeze and reset.
module tb_step_renderer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        enable_anim;
  logic [10:0] pixelX, pixelY, tileTopLeftX, tileTopLeftY;
  logic [2:0]  step_type;

  logic [10:0] offsetX, offsetY, offsetX2, offsetY2;
  logic        drawingRequest, drawingRequest2;
  logic [7:0]  RGBout, RGBout2;
  logic [5:0]  spikeHeight, spikeHeight2;
  logic        spikeActive, spikeActive2;

  typedef struct {
    logic        draw;
    logic [7:0]  rgb;
    logic [10:0] ox;
    logic [10:0] oy;
  } expect_t;

  expect_t expQ[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  step_renderer dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable_anim(enable_anim),
    .pixelX(pixelX), .pixelY(pixelY), .tileTopLeftX(tileTopLeftX), .tileTopLeftY(tileTopLeftY),
    .step_type(step_type), .offsetX(offsetX), .offsetY(offsetY),
    .drawingRequest(drawingRequest), .RGBout(RGBout),
    .spikeHeight(spikeHeight), .spikeActive(spikeActive)
  );

  // Second instance with the step flush against the tile top, so a full
  // spike reaches above the screen and must clamp at row 0.
  step_renderer #(.STEP_TILE_OFFSET_Y(0)) dutClamp (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable_anim(enable_anim),
    .pixelX(pixelX), .pixelY(pixelY), .tileTopLeftX(tileTopLeftX), .tileTopLeftY(tileTopLeftY),
    .step_type(step_type), .offsetX(offsetX2), .offsetY(offsetY2),
    .drawingRequest(drawingRequest2), .RGBout(RGBout2),
    .spikeHeight(spikeHeight2), .spikeActive(spikeActive2)
  );

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel at a falling edge and queue the result due next cycle.
  task automatic applyStimulus(input string tag, input logic [2:0] typ,
                               input int tx, input int ty, input int px, input int py,
                               input logic eDraw, input logic [7:0] eRgb,
                               input int eOx, input int eOy);
    expect_t e;
    step_type    = typ;
    tileTopLeftX = 11'(tx);
    tileTopLeftY = 11'(ty);
    pixelX       = 11'(px);
    pixelY       = 11'(py);
    e.draw = eDraw;  e.rgb = eRgb;  e.ox = 11'(eOx);  e.oy = 11'(eOy);
    expQ.push_back(e);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: observed=empty-queue expected=entry", tag);
    end else begin
      e = expQ.pop_front();
      checkVal({tag, ".draw"}, 16'(drawingRequest), 16'(e.draw));
      checkVal({tag, ".rgb"},  16'(RGBout), 16'(e.rgb));
      checkVal({tag, ".offX"}, 16'(offsetX), 16'(e.ox));
      checkVal({tag, ".offY"}, 16'(offsetY), 16'(e.oy));
    end
  endtask

  task automatic pulseFrames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic checkSpike(input string tag, input int eH, input logic eA);
    checkVal({tag, ".height"}, 16'(spikeHeight), 16'(eH));
    checkVal({tag, ".active"}, 16'(spikeActive), 16'(eA));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;  startOfFrame = 1'b0;  enable_anim = 1'b0;
    step_type = 3'd1;  tileTopLeftX = 11'd64;  tileTopLeftY = 11'd64;
    pixelX = 11'd71;  pixelY = 11'd114;
    repeat (3) @(negedge clk);
    checkVal("reset.draw", 16'(drawingRequest), 16'd0);
    checkVal("reset.rgb",  16'(RGBout), 16'h00);
    checkVal("reset.offX", 16'(offsetX), 16'd0);
    checkVal("reset.offY", 16'(offsetY), 16'd0);
    checkSpike("reset", 0, 1'b0);
    resetN = 1'b1;
    @(negedge clk);

    // Step kinds and region edges.
    applyStimulus("reguTopLeft",  3'd1, 64, 64, 71, 114,  1'b1, 8'h8b, 0, 0);
    applyStimulus("reguRightOut", 3'd1, 64, 64, 121, 114, 1'b0, 8'hFF, 0, 0);
    applyStimulus("reguBotRight", 3'd1, 64, 64, 120, 120, 1'b1, 8'h8b, 49, 6);
    applyStimulus("reguBelow",    3'd1, 64, 64, 71, 121,  1'b0, 8'hFF, 0, 0);
    applyStimulus("reguLeftOut",  3'd1, 64, 64, 70, 114,  1'b0, 8'hFF, 0, 0);
    applyStimulus("gate",         3'd2, 64, 64, 80, 116,  1'b1, 8'h1c, 9, 2);
    applyStimulus("death",        3'd3, 64, 64, 100, 115, 1'b1, 8'he0, 29, 1);
    applyStimulus("free",         3'd0, 64, 64, 80, 116,  1'b0, 8'hFF, 0, 0);
    applyStimulus("wallCorner",   3'd4, 0, 0, 63, 63,     1'b1, 8'h49, 63, 63);
    applyStimulus("wallRightOut", 3'd4, 0, 0, 64, 63,     1'b0, 8'hFF, 0, 0);
    applyStimulus("wallOrigin",   3'd4, 0, 0, 0, 0,       1'b1, 8'h49, 0, 0);
    applyStimulus("farRight",     3'd1, 2040, 0, 2047, 50, 1'b1, 8'h8b, 0, 0);
    applyStimulus("farRightLow",  3'd1, 2040, 0, 5, 50,   1'b0, 8'hFF, 0, 0);
    applyStimulus("spikeDown",    3'd5, 0, 0, 7, 50,      1'b1, 8'hb6, 0, 0);
    applyStimulus("spikeDownAbv", 3'd5, 0, 0, 7, 49,      1'b0, 8'hFF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("invalid7", 3'd7, 64, 64, 71 + 10 * i, 114 + i, 1'b0, 8'hFF, 0, 0);
    end
    applyStimulus("invalid6", 3'd6, 0, 0, 10, 10, 1'b0, 8'hFF, 0, 0);

    // Animation timeline.
    enable_anim = 1'b1;
    pulseFrames(30);  checkSpike("hold30", 0, 1'b0);
    pulseFrames(1);   checkSpike("rise1", 1, 1'b0);
    pulseFrames(8);   checkSpike("rise9", 9, 1'b0);
    pulseFrames(1);   checkSpike("rise10", 10, 1'b1);
    pulseFrames(10);  checkSpike("rise20", 20, 1'b1);

    applyStimulus("spikeTop",    3'd5, 0, 0, 7, 30,  1'b1, 8'hb6, 0, 0);
    applyStimulus("spikeAbove",  3'd5, 0, 0, 7, 29,  1'b0, 8'hFF, 0, 0);
    applyStimulus("spikeCorner", 3'd5, 0, 0, 56, 56, 1'b1, 8'hb6, 49, 26);
    applyStimulus("spikeRight",  3'd5, 0, 0, 57, 56, 1'b0, 8'hFF, 0, 0);
    checkVal("clamp.draw", 16'(drawingRequest2), 16'd0);
    applyStimulus("clampMain",   3'd5, 0, 0, 7, 0,   1'b0, 8'hFF, 0, 0);
    checkVal("clamp.draw", 16'(drawingRequest2), 16'd1);
    checkVal("clamp.rgb",  16'(RGBout2), 16'hb6);
    checkVal("clamp.offX", 16'(offsetX2), 16'd0);
    checkVal("clamp.offY", 16'(offsetY2), 16'd0);
    checkVal("clamp.height", 16'(spikeHeight2), 16'd20);

    pulseFrames(30);  checkSpike("extended30", 20, 1'b1);
    pulseFrames(1);   checkSpike("fall1", 19, 1'b1);
    pulseFrames(19);  checkSpike("fall20", 0, 1'b0);
    pulseFrames(1);   checkSpike("retracted", 0, 1'b0);

    // Back into RISING, then freeze at height 5.
    pulseFrames(29);  checkSpike("holdAgain", 0, 1'b0);
    pulseFrames(5);   checkSpike("rise5", 5, 1'b0);
    enable_anim = 1'b0;
    pulseFrames(10);  checkSpike("frozen", 5, 1'b0);
    enable_anim = 1'b1;

    // Asynchronous reset between clock edges.
    #2 resetN = 1'b0;
    #1 checkSpike("asyncReset", 0, 1'b0);
    checkVal("asyncReset.rgb", 16'(RGBout), 16'h00);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    pulseFrames(30);  checkSpike("postReset30", 0, 1'b0);
    pulseFrames(1);   checkSpike("postReset31", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
